alu_ctrl_issue: RTL

// Registered, multi-lane successor to the single-lane ALU control decoder. Each cycle it takes up to LANES
// {Op, funct3, funct7} tuples from the issue stage and decodes each into an ALUOp. It applies in-order,
// per-lane acceptance, and holds each ALUOp in one output pipeline register. It also schedules the one

---
 rtl/alu_ctrl_issue_if.sv | 29 ++
 rtl/alu_ctrl_issue.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_issue_if.sv
// Issue-side and output-side bundle of the multi-lane ALU control decoder.
// The master side is the issue stage plus the downstream consumer; the slave side is the decoder.
interface alu_ctrl_issue_if #(
    parameter int LANES = 2,
    parameter int OPW   = 5
);
    logic [LANES-1:0]     in_valid;
    logic [LANES-1:0]     in_ready;
    logic [2*LANES-1:0]   in_op;
    logic [3*LANES-1:0]   in_funct3;
    logic [7*LANES-1:0]   in_funct7;
    logic [LANES-1:0]     out_valid;
    logic                 out_ready;
    logic [OPW*LANES-1:0] out_aluop;
    logic [LANES-1:0]     out_illegal;
    logic [LANES-1:0]     out_mclass;
    logic                 md_busy;
    logic [15:0]          stall_cnt;

    modport master (
        output in_valid, in_op, in_funct3, in_funct7, out_ready,
        input  in_ready, out_valid, out_aluop, out_illegal, out_mclass, md_busy, stall_cnt
    );

    modport slave (
        input  in_valid, in_op, in_funct3, in_funct7, out_ready,
        output in_ready, out_valid, out_aluop, out_illegal, out_mclass, md_busy, stall_cnt
    );
endinterface

// File: rtl/alu_ctrl_issue.sv
// Multi-lane registered ALU control decoder with in-order acceptance and scheduling
// of a single shared multi-cycle mul/div unit.
module alu_ctrl_issue #(
    parameter int LANES   = 2,
    parameter int OPW     = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input logic             clk,
    input logic             rst,
    alu_ctrl_issue_if.slave bus
);
    localparam int CW = $clog2(DIV_LAT + 1);

    typedef logic [4:0] code_t;

    localparam code_t C_ADD  = 5'b00000;
    localparam code_t C_SUB  = 5'b00001;
    localparam code_t C_AND  = 5'b00100;
    localparam code_t C_OR   = 5'b00101;
    localparam code_t C_XOR  = 5'b00110;
    localparam code_t C_SLL  = 5'b00111;
    localparam code_t C_SRL  = 5'b01000;
    localparam code_t C_SRA  = 5'b01001;
    localparam code_t C_SLTU = 5'b01010;
    localparam code_t C_SLT  = 5'b01011;
    localparam code_t C_ILL  = 5'b11111;

    function automatic code_t decode(input logic [1:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7);
        code_t c;
        c = C_ILL;
        case (op)
            2'b00: c = C_ADD;
            2'b01: c = C_SUB;
            2'b10: begin
                case ({f7, f3})
                    {7'h00, 3'b000}: c = C_ADD;
                    {7'h20, 3'b000}: c = C_SUB;
                    {7'h00, 3'b111}: c = C_AND;
                    {7'h00, 3'b110}: c = C_OR;
                    {7'h00, 3'b100}: c = C_XOR;
                    {7'h00, 3'b001}: c = C_SLL;
                    {7'h00, 3'b101}: c = C_SRL;
                    {7'h20, 3'b101}: c = C_SRA;
                    {7'h00, 3'b011}: c = C_SLTU;
                    {7'h00, 3'b010}: c = C_SLT;
                    {7'h01, 3'b000}: c = 5'b01100;
                    {7'h01, 3'b001}: c = 5'b01101;
                    {7'h01, 3'b010}: c = 5'b10100;
                    {7'h01, 3'b011}: c = 5'b10001;
                    {7'h01, 3'b100}: c = 5'b10010;
                    {7'h01, 3'b101}: c = 5'b01110;
                    {7'h01, 3'b110}: c = 5'b10011;
                    {7'h01, 3'b111}: c = 5'b01111;
                    default:         c = C_ILL;
                endcase
            end
            default: begin
                // Immediates ignore funct7 except for the shift encodings.
                case (f3)
                    3'b000:  c = C_ADD;
                    3'b111:  c = C_AND;
                    3'b110:  c = C_OR;
                    3'b100:  c = C_XOR;
                    3'b011:  c = C_SLTU;
                    3'b010:  c = C_SLT;
                    3'b001:  c = (f7 == 7'h00) ? C_SLL : C_ILL;
                    default: c = (f7 == 7'h00) ? C_SRL : ((f7 == 7'h20) ? C_SRA : C_ILL);
                endcase
            end
        endcase
        return c;
    endfunction

    code_t            code [LANES];
    logic [LANES-1:0] mclass;
    logic [LANES-1:0] is_div;
    logic [LANES-1:0] mhaz;
    logic [LANES-1:0] ready;
    logic             stage_free;
    logic             start_m;
    logic             start_div;
    logic             stall_hit;
    logic             prefix;
    logic             seen_m;

    logic [LANES-1:0]     valid_q;
    logic [OPW*LANES-1:0] aluop_q;
    logic [LANES-1:0]     illegal_q;
    logic [LANES-1:0]     mclass_q;
    logic [CW-1:0]        md_cnt;
    logic [15:0]          stall_q;

    assign stage_free = ~|valid_q | bus.out_ready;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        prefix    = 1'b1;
        seen_m    = 1'b0;
        start_m   = 1'b0;
        start_div = 1'b0;
        stall_hit = 1'b0;
        mclass    = '0;
        is_div    = '0;
        mhaz      = '0;
        ready     = '0;
        for (int i = 0; i < LANES; i++) begin
            code[i]   = decode(bus.in_op[2*i +: 2], bus.in_funct3[3*i +: 3], bus.in_funct7[7*i +: 7]);
            is_div[i] = code[i] inside {5'b10010, 5'b01110, 5'b10011, 5'b01111};
            mclass[i] = is_div[i] | (code[i] inside {5'b01100, 5'b01101, 5'b10100, 5'b10001});
            // A lane's M hazard sees only lower lanes, so the accepted set stays an in-order prefix.
            mhaz[i]   = mclass[i] & ((md_cnt != '0) | seen_m);
            ready[i]  = ~rst & stage_free & prefix & ~mhaz[i];
            prefix    = ready[i];
            seen_m    = seen_m | (bus.in_valid[i] & mclass[i]);
            stall_hit = stall_hit | (bus.in_valid[i] & mhaz[i]);
            if (bus.in_valid[i] & ready[i] & mclass[i]) begin
                start_m   = 1'b1;
                start_div = is_div[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            aluop_q   <= '0;
            illegal_q <= '0;
            mclass_q  <= '0;
            md_cnt    <= '0;
            stall_q   <= '0;
        end else begin
            if (stage_free) begin
                for (int i = 0; i < LANES; i++) begin
                    valid_q[i]            <= bus.in_valid[i] & ready[i];
                    aluop_q[OPW*i +: OPW] <= OPW'(code[i]);
                    illegal_q[i]          <= (code[i] == C_ILL);
                    mclass_q[i]           <= mclass[i];
                end
            end
            if (start_m) begin
                md_cnt <= start_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - CW'(1);
            end
            if (stall_hit && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = valid_q;
    assign bus.out_aluop   = aluop_q;
    assign bus.out_illegal = illegal_q;
    assign bus.out_mclass  = mclass_q;
    assign bus.md_busy     = (md_cnt != '0);
    assign bus.stall_cnt   = stall_q;
endmodule
